// File: rtl/baud_tick_generator_if.sv
// Bus between the UART and the baud tick generator.
// master : UART side, drives enable, divisor load, sync; observes ticks.
// slave  : generator side.
//   enable     count enable
//   div_load   one-cycle strobe loading div_in
//   div_in     new divisor {I, F}
//   sync       one-cycle phase restart
//   div_value  active divisor {I, F}
//   div_err    sticky rejected-load flag
//   rx_tick    oversampling tick
//   rx_mid     mid-bit sample strobe
//   tx_tick    bit-rate tick
//   phase      oversample index within the bit
interface baud_tick_generator_if #(
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_BITS  = 4,
    parameter int OVERSAMPLE = 16
);
    localparam int DIV_W = INT_WIDTH + FRAC_BITS;
    localparam int PH_W  = $clog2(OVERSAMPLE);

    logic             enable;
    logic             div_load;
    logic [DIV_W-1:0] div_in;
    logic             sync;
    logic [DIV_W-1:0] div_value;
    logic             div_err;
    logic             rx_tick;
    logic             rx_mid;
    logic             tx_tick;
    logic [PH_W-1:0]  phase;

    modport master (
        output enable, div_load, div_in, sync,
        input  div_value, div_err, rx_tick, rx_mid, tx_tick, phase
    );

    modport slave (
        input  enable, div_load, div_in, sync,
        output div_value, div_err, rx_tick, rx_mid, tx_tick, phase
    );
endinterface

// File: rtl/baud_tick_generator.sv
// Runtime-programmable fractional baud tick source.
// Divides clk by D = I + F/2^FRAC_BITS to give the oversampling tick
// rx_tick, and decodes tx_tick (once per bit) and rx_mid (bit centre)
// from the oversample phase.
// Ports:
//   clk   single clock
//   rst   synchronous active-high reset
//   bus   baud_tick_generator_if.slave (see interface file)
module baud_tick_generator #(
    parameter int CLK_RATE   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    baud_tick_generator_if.slave  bus
);
    localparam int DIV_W = INT_WIDTH + FRAC_BITS;
    localparam int PH_W  = $clog2(OVERSAMPLE);

    // Rounded divisor for the reset baud rate, in 1/2^FRAC_BITS clk units.
    localparam logic [63:0] DEF_WIDE =
        (64'(CLK_RATE) * (64'd1 << FRAC_BITS) + (64'(BAUD_RATE) * 64'(OVERSAMPLE)) / 64'd2)
        / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
    localparam logic [DIV_W-1:0]     DEF   = DEF_WIDE[DIV_W-1:0];
    localparam logic [INT_WIDTH-1:0] DEF_I = DEF[DIV_W-1:FRAC_BITS];

    logic [DIV_W-1:0]     div_value_q;
    logic                 div_err_q;
    logic [INT_WIDTH-1:0] cnt;
    logic [FRAC_BITS-1:0] acc;
    logic [PH_W-1:0]      phase_q;

    logic [INT_WIDTH-1:0] cur_i;
    logic [FRAC_BITS-1:0] cur_f;
    logic [INT_WIDTH-1:0] new_i;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 load_ok;
    logic                 tick;

    assign cur_i   = div_value_q[DIV_W-1:FRAC_BITS];
    assign cur_f   = div_value_q[FRAC_BITS-1:0];
    assign new_i   = bus.div_in[DIV_W-1:FRAC_BITS];
    assign load_ok = bus.div_load && (new_i >= INT_WIDTH'(2));
    // Carry out of the fractional accumulator stretches the next period by one.
    assign acc_sum = {1'b0, acc} + {1'b0, cur_f};
    assign tick    = bus.enable && !rst && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_value_q <= DEF;
            div_err_q   <= 1'b0;
            cnt         <= DEF_I - INT_WIDTH'(1);
            acc         <= '0;
            phase_q     <= '0;
        end else if (load_ok) begin
            div_value_q <= bus.div_in;
            div_err_q   <= 1'b0;
            cnt         <= new_i - INT_WIDTH'(1);
            acc         <= '0;
            phase_q     <= '0;
        end else begin
            if (bus.div_load) begin
                div_err_q <= 1'b1;
            end
            if (bus.sync) begin
                cnt     <= cur_i - INT_WIDTH'(1);
                acc     <= '0;
                phase_q <= '0;
            end else if (tick) begin
                cnt     <= acc_sum[FRAC_BITS] ? cur_i : cur_i - INT_WIDTH'(1);
                acc     <= acc_sum[FRAC_BITS-1:0];
                phase_q <= phase_q + PH_W'(1);
            end else if (bus.enable) begin
                cnt <= cnt - INT_WIDTH'(1);
            end
        end
    end

    assign bus.rx_tick   = tick;
    assign bus.tx_tick   = tick && (phase_q == PH_W'(OVERSAMPLE - 1));
    assign bus.rx_mid    = tick && (phase_q == PH_W'(OVERSAMPLE / 2 - 1));
    assign bus.phase     = phase_q;
    assign bus.div_value = div_value_q;
    assign bus.div_err   = div_err_q;
endmodule

// File: tb/tb_baud_tick_generator.sv
module tb_baud_tick_generator;
    localparam int OS = 16;
    localparam int FB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    baud_tick_generator_if #(.INT_WIDTH(16), .FRAC_BITS(4), .OVERSAMPLE(16)) bus ();

    baud_tick_generator #(
        .CLK_RATE(50000000), .BAUD_RATE(115200), .OVERSAMPLE(16),
        .INT_WIDTH(16), .FRAC_BITS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: k-th tick after a restart lands on enabled cycle
    // k*I + floor((k-1)*F / 2^FB).
    int          m_i, m_f, m_n, m_k;
    logic [19:0] m_div;
    logic        m_err;

    logic        e_rx, e_tx, e_mid, e_err, a_rx, a_tx, a_mid, a_err;
    logic [3:0]  e_ph, a_ph;
    logic [19:0] e_div, a_div;

    function automatic int tick_time(int k);
        return k * m_i + (((k - 1) * m_f) >> FB);
    endfunction

    task automatic model_reset();
        m_i = 27; m_f = 2; m_div = 20'd434; m_err = 1'b0; m_n = 0; m_k = 0;
    endtask

    // One clock: inputs already driven after a negedge. Samples DUT and model
    // before the posedge, applies the edge to the model, returns at negedge.
    task automatic cycle();
        #1;
        e_rx  = !rst && bus.enable && (m_n + 1 == tick_time(m_k + 1));
        e_ph  = 4'(m_k % OS);
        e_tx  = e_rx && (e_ph == 4'(OS - 1));
        e_mid = e_rx && (e_ph == 4'(OS / 2 - 1));
        e_div = m_div;
        e_err = m_err;
        a_rx = bus.rx_tick; a_tx = bus.tx_tick; a_mid = bus.rx_mid;
        a_ph = bus.phase;   a_div = bus.div_value; a_err = bus.div_err;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (bus.div_load && (bus.div_in[19:4] >= 16'd2)) begin
            m_div = bus.div_in; m_i = int'(bus.div_in[19:4]); m_f = int'(bus.div_in[3:0]);
            m_err = 1'b0; m_n = 0; m_k = 0;
        end else begin
            if (bus.div_load) m_err = 1'b1;
            if (bus.sync) begin
                m_n = 0; m_k = 0;
            end else if (bus.enable) begin
                if (e_rx) m_k++;
                m_n++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b1; bus.div_load = 1'b0; bus.sync = 1'b0; bus.div_in = '0;
        @(negedge clk);
        cycle();
        compared++;
        if ({a_rx, a_tx, a_mid} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ticks: got rx/tx/mid=%b%b%b want 000", a_rx, a_tx, a_mid);
        end
        cycle();
        compared++;
        if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {3'b000, 4'd0, 20'd434, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got rx/tx/mid=%b%b%b ph=%0d div=%0d err=%b want 000 ph=0 div=434 err=0",
                     a_rx, a_tx, a_mid, a_ph, a_div, a_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_default_rates();
        int first = 0, last_tx = 0, ntx = 0;
        for (int i = 1; i <= 3472; i++) begin
            cycle();
            compared++;
            if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {e_rx, e_tx, e_mid, e_ph, e_div, e_err}) begin
                mismatched++;
                $display("FAIL default_rates cyc %0d: got rx/tx/mid=%b%b%b ph=%0d div=%h err=%b want %b%b%b ph=%0d div=%h err=%b",
                         i, a_rx, a_tx, a_mid, a_ph, a_div, a_err, e_rx, e_tx, e_mid, e_ph, e_div, e_err);
            end
            if (a_rx && first == 0) first = i;
            if (a_mid && last_tx != 0) begin
                compared++;
                if (i - last_tx != 217) begin
                    mismatched++;
                    $display("FAIL default_mid_offset: got %0d want 217", i - last_tx);
                end
            end
            if (a_tx) begin
                if (last_tx != 0) begin
                    compared++;
                    if (i - last_tx != 434) begin
                        mismatched++;
                        $display("FAIL default_tx_period: got %0d want 434", i - last_tx);
                    end
                end
                last_tx = i;
                ntx++;
            end
        end
        compared++;
        if (first != 27) begin
            mismatched++;
            $display("FAIL default_first_tick: got cycle %0d want 27", first);
        end
        compared++;
        if (ntx != 8) begin
            mismatched++;
            $display("FAIL default_tx_count: got %0d want 8", ntx);
        end
    endtask

    task automatic test_integer_load();
        int last_rx = 0, last_tx = 0;
        bus.div_in = 20'h000A0; bus.div_load = 1'b1;
        cycle();
        bus.div_load = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            cycle();
            compared++;
            if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {e_rx, e_tx, e_mid, e_ph, e_div, e_err}) begin
                mismatched++;
                $display("FAIL integer_load cyc %0d: got rx/tx/mid=%b%b%b ph=%0d div=%h err=%b want %b%b%b ph=%0d div=%h err=%b",
                         i, a_rx, a_tx, a_mid, a_ph, a_div, a_err, e_rx, e_tx, e_mid, e_ph, e_div, e_err);
            end
            if (i == 1) begin
                compared++;
                if (a_div !== 20'h000A0) begin
                    mismatched++;
                    $display("FAIL integer_readback: got %h want 000a0", a_div);
                end
            end
            if (a_rx) begin
                compared++;
                if ((last_rx == 0 && i != 10) || (last_rx != 0 && i - last_rx != 10)) begin
                    mismatched++;
                    $display("FAIL integer_rx_period: got tick at %0d after %0d want spacing 10", i, last_rx);
                end
                last_rx = i;
            end
            if (a_tx) begin
                if (last_tx != 0) begin
                    compared++;
                    if (i - last_tx != 160) begin
                        mismatched++;
                        $display("FAIL integer_tx_period: got %0d want 160", i - last_tx);
                    end
                end
                last_tx = i;
            end
        end
    endtask

    task automatic test_rejected_load();
        bus.div_in = {16'd1, 4'd5}; bus.div_load = 1'b1;
        cycle();
        bus.div_load = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            compared++;
            if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {e_rx, e_tx, e_mid, e_ph, e_div, e_err}) begin
                mismatched++;
                $display("FAIL rejected_load cyc %0d: got rx/tx/mid=%b%b%b ph=%0d div=%h err=%b want %b%b%b ph=%0d div=%h err=%b",
                         i, a_rx, a_tx, a_mid, a_ph, a_div, a_err, e_rx, e_tx, e_mid, e_ph, e_div, e_err);
            end
        end
        compared++;
        if ({a_err, a_div} !== {1'b1, 20'h000A0}) begin
            mismatched++;
            $display("FAIL rejected_flag: got err=%b div=%h want err=1 div=000a0", a_err, a_div);
        end
        bus.div_in = {16'd4, 4'd0}; bus.div_load = 1'b1;
        cycle();
        bus.div_load = 1'b0;
        cycle();
        compared++;
        if ({a_err, a_div} !== {1'b0, 20'h00040}) begin
            mismatched++;
            $display("FAIL rejected_clear: got err=%b div=%h want err=0 div=00040", a_err, a_div);
        end
    endtask

    task automatic test_min_divisor();
        logic [19:0] divs [2];
        divs[0] = {16'd2, 4'd0};
        divs[1] = {16'd2, 4'd15};
        for (int d = 0; d < 2; d++) begin
            bus.div_in = divs[d]; bus.div_load = 1'b1;
            cycle();
            bus.div_load = 1'b0;
            for (int i = 1; i <= 64; i++) begin
                cycle();
                compared++;
                if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {e_rx, e_tx, e_mid, e_ph, e_div, e_err}) begin
                    mismatched++;
                    $display("FAIL min_divisor d%0d cyc %0d: got rx/tx/mid=%b%b%b ph=%0d div=%h want %b%b%b ph=%0d div=%h",
                             d, i, a_rx, a_tx, a_mid, a_ph, a_div, e_rx, e_tx, e_mid, e_ph, e_div);
                end
            end
        end
    endtask

    task automatic test_sync();
        int n_rx = 0, guard = 0;
        bool_dummy: begin end
        bus.div_in = {16'd10, 4'd0}; bus.div_load = 1'b1;
        cycle();
        bus.div_load = 1'b0;
        while ((m_k % OS) != 11 && guard < 2000) begin
            cycle();
            guard++;
        end
        compared++;
        if (guard >= 2000) begin
            mismatched++;
            $display("FAIL sync_reach_phase: got timeout want phase 11");
        end
        bus.sync = 1'b1;
        cycle();
        bus.sync = 1'b0;
        cycle();
        compared++;
        if (a_ph !== 4'd0) begin
            mismatched++;
            $display("FAIL sync_phase_zero: got %0d want 0", a_ph);
        end
        guard = 0;
        while (!a_tx && guard < 1000) begin
            cycle();
            guard++;
            compared++;
            if ({a_rx, a_tx, a_mid, a_ph} !== {e_rx, e_tx, e_mid, e_ph}) begin
                mismatched++;
                $display("FAIL sync_track: got rx/tx/mid=%b%b%b ph=%0d want %b%b%b ph=%0d",
                         a_rx, a_tx, a_mid, a_ph, e_rx, e_tx, e_mid, e_ph);
            end
            if (a_rx) n_rx++;
            if (a_mid) begin
                compared++;
                if (n_rx != 8) begin
                    mismatched++;
                    $display("FAIL sync_mid_count: got %0d ticks want 8", n_rx);
                end
            end
        end
        compared++;
        if (n_rx != 16) begin
            mismatched++;
            $display("FAIL sync_tx_count: got %0d ticks want 16", n_rx);
        end
        // sync together with a valid load behaves as the load alone
        bus.div_in = {16'd6, 4'd3}; bus.div_load = 1'b1; bus.sync = 1'b1;
        cycle();
        bus.div_load = 1'b0; bus.sync = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            compared++;
            if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {e_rx, e_tx, e_mid, e_ph, e_div, e_err}) begin
                mismatched++;
                $display("FAIL sync_with_load cyc %0d: got rx/tx/mid=%b%b%b ph=%0d div=%h want %b%b%b ph=%0d div=%h",
                         i, a_rx, a_tx, a_mid, a_ph, a_div, e_rx, e_tx, e_mid, e_ph, e_div);
            end
        end
    endtask

    task automatic test_enable_gating();
        int guard = 0, n_rx = 0, wait_n = 0;
        while ((tick_time(m_k + 1) - (m_n + 1)) != 5 && guard < 100) begin
            cycle();
            guard++;
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (a_rx || a_tx || a_mid) n_rx++;
        end
        compared++;
        if (n_rx != 0) begin
            mismatched++;
            $display("FAIL gating_no_ticks: got %0d ticks want 0", n_rx);
        end
        bus.enable = 1'b1;
        do begin
            cycle();
            wait_n++;
        end while (!a_rx && wait_n < 20);
        compared++;
        if (wait_n != 6) begin
            mismatched++;
            $display("FAIL gating_resume: got tick on enabled cycle %0d want 6", wait_n);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while ((m_k % OS) != 7 && guard < 2000) begin
            cycle();
            guard++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        compared++;
        if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {3'b000, 4'd0, 20'd434, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_mid: got rx/tx/mid=%b%b%b ph=%0d div=%0d err=%b want 000 ph=0 div=434 err=0",
                     a_rx, a_tx, a_mid, a_ph, a_div, a_err);
        end
    endtask

    task automatic test_random();
        for (int i = 1; i <= 3000; i++) begin
            bus.enable   = ($urandom_range(0, 9) < 8);
            bus.sync     = ($urandom_range(0, 49) == 0);
            bus.div_load = ($urandom_range(0, 99) == 0);
            bus.div_in   = {16'($urandom_range(0, 12)), 4'($urandom_range(0, 15))};
            cycle();
            compared++;
            if ({a_rx, a_tx, a_mid, a_ph, a_div, a_err} !== {e_rx, e_tx, e_mid, e_ph, e_div, e_err}) begin
                mismatched++;
                $display("FAIL random cyc %0d: got rx/tx/mid=%b%b%b ph=%0d div=%h err=%b want %b%b%b ph=%0d div=%h err=%b",
                         i, a_rx, a_tx, a_mid, a_ph, a_div, a_err, e_rx, e_tx, e_mid, e_ph, e_div, e_err);
            end
        end
        bus.enable = 1'b1; bus.sync = 1'b0; bus.div_load = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_rates();
        test_integer_load();
        test_rejected_load();
        test_min_divisor();
        test_sync();
        test_enable_gating();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/baud_tick_generator.md
# baud_tick_generator

Runtime-programmable baud tick source for the full-duplex UART, replacing the fixed-ratio baud generator. It divides `clk` by a fractional divisor to produce an oversampling tick (`rx_tick`) for the receiver. From that it derives a 1x bit tick (`tx_tick`) for the transmitter and a mid-bit sample strobe (`rx_mid`). Software can change the divisor without resynthesis, and the receiver can re-align the bit phase to a start-bit edge.

## Interface
- `CLK_RATE`, 50000000: input clock frequency, Hz.
- `BAUD_RATE`, 115200: baud rate loaded at reset.
- `OVERSAMPLE`, 16: `rx_tick` pulses per bit. Power of two, 4..64.
- `INT_WIDTH`, 16: width of the integer divisor field.
- `FRAC_BITS`, 4: width of the fractional divisor field.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: count enable. While low, counters freeze and no ticks are emitted.
- `div_load` input, 1 bit: single-cycle strobe that loads `div_in`.
- `div_in` input, INT_WIDTH+FRAC_BITS bits: new divisor in {I, F} format; the integer part I is in the upper bits.
- `sync` input, 1 bit: single-cycle phase restart, used by the receiver on a start-bit edge.
- `div_value` output, INT_WIDTH+FRAC_BITS bits: the divisor currently active.
- `div_err` output, 1 bit: sticky flag; a load was rejected.
- `rx_tick` output, 1 bit: oversampling tick.
- `rx_mid` output, 1 bit: mid-bit sample strobe.
- `tx_tick` output, 1 bit: bit-rate tick.
- `phase` output, log2(OVERSAMPLE) bits: current oversample index within the bit.

## Operation
- **Divisor meaning.** D = I + F/2^FRAC_BITS, in clk cycles per `rx_tick`. Legal range is I >= 2.
- **Reset divisor.** DEF = (CLK_RATE*2^FRAC_BITS + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), integer division, evaluated at elaboration. With the default parameters, DEF = 434, so I = 27 and F = 2.
- **State.**
  - `cnt` (INT_WIDTH bits): counts down.
  - `acc` (FRAC_BITS bits): fractional accumulator.
  - `phase`: oversample index.
  - `div_value`, `div_err`.
- **Counting** (every cycle with `enable` = 1):
  - If `cnt` != 0, decrement `cnt`.
  - If `cnt` == 0, `rx_tick` is asserted and the reload is computed as {carry, acc_next} = acc + F.
  - On carry, `cnt` reloads with I, giving a period of I+1. Otherwise it reloads with I-1, giving a period of I.
  - Long-run mean period is exactly D.
- **Tick decode.** All three ticks are combinational decodes of registered state:
  - `rx_tick` = `enable` & (`cnt` == 0).
  - `tx_tick` = `rx_tick` & (`phase` == OVERSAMPLE-1).
  - `rx_mid` = `rx_tick` & (`phase` == OVERSAMPLE/2-1).
  - `phase` increments on every `rx_tick` and wraps from OVERSAMPLE-1 to 0.
- **Restart state** (after reset, valid load or `sync`): `cnt` = I-1, `acc` = 0, `phase` = 0.
- **Divisor load.**
  - If `div_load` = 1 and `div_in` has I >= 2: `div_value` <= `div_in`, `div_err` <= 0, and the counters take the restart state computed from the new divisor.
  - If I < 2: the load is ignored (divisor and counters are unchanged) and `div_err` <= 1.
  - Loads are honoured regardless of `enable`.
- **Sync.** `sync` = 1 forces the restart state using the current `div_value`. The first `rx_mid` after a sync therefore falls OVERSAMPLE/2 ticks later, at the centre of the start bit.
- **Priority:** `rst` > valid `div_load` > `sync` > counting. An invalid `div_load` in the same cycle as `sync` still sets `div_err`, and `sync` is applied.

## Timing
- **Reset values:**
  - `div_value` = DEF, `div_err` = 0, `phase` = 0.
  - `cnt` = DEF[INT]-1, `acc` = 0.
  - `rx_tick`, `tx_tick`, `rx_mid` = 0 while `rst` = 1.
- **First tick.** After reset, load or sync, `rx_tick` is high during the I-th enabled cycle. With the default divisor, that is the 27th cycle.
- **Tick shape.** Every tick is exactly one `clk` wide. Ticks never occur while `enable` = 0 or `rst` = 1.
- **Enable.** Deasserting `enable` freezes `cnt`, `acc` and `phase`. Reasserting it resumes from the same count, so the phase is not lost.
- **Load latency.** A load takes effect on the edge that samples `div_load`. The next cycle counts with the new divisor.
- **Mid-operation reset or load.** Either one abandons the current bit phase immediately. No partial tick is emitted.
- **Minimum divisor.** With I = 2 and F = 0, `rx_tick` fires every 2nd cycle. With I = 2 and F = 2^FRAC_BITS-1, period 3 is interleaved with period 2.

## Test plan
- **Default rates.** Reset, then `enable` = 1 for 3472 cycles.
  - First `rx_tick` at cycle 27.
  - Each group of 8 `rx_tick`s spans 217 cycles (seven periods of 27, one of 28).
  - `tx_tick` every 434 cycles; 8 `tx_tick`s in total.
  - `rx_mid` is 217 cycles after the first cycle of each bit.
- **Integer load.** Load `div_in` = {I=10, F=0}.
  - `rx_tick` every 10 cycles.
  - `tx_tick` every 160 cycles.
  - `phase` sequence 0..15 and wraps.
  - `div_value` reads back 0x000A0.
- **Rejected load.** Load {I=1, F=5}.
  - `div_err` = 1; `div_value` is unchanged; tick cadence is undisturbed.
  - A following valid load {I=4, F=0} clears `div_err`.
- **Sync mid-bit.** With `phase` = 11, pulse `sync`.
  - `phase` = 0 next cycle.
  - `rx_mid` fires 8 `rx_tick`s later.
  - `tx_tick` fires 16 `rx_tick`s after the sync.
  - A `sync` simultaneous with a valid `div_load` behaves as the load alone.
- **Enable gating.** Drop `enable` for 50 cycles when `cnt` = 5.
  - No ticks while `enable` is low; `cnt` stays at 5.
  - Next `rx_tick` 6 enabled cycles after `enable` returns.
- **Reset mid-bit.** Assert `rst` for 1 cycle at `phase` = 7.
  - All outputs return to their reset values.
  - `div_value` = 434, even if a different divisor had been loaded.
